// File: rtl/trace_pkg.sv
// trace_pkg: shared types and constants for the trace buffer.
//   TRACE_ADDR_W  - data-memory word address width
//   TRACE_DATA_W  - width of the data fields held in a trace entry. The
//                   trace_buffer DATA_W parameter must equal this value.
//   trace_entry_t - one captured retirement event. The ts field exists only
//                   when TRACE_TIMESTAMP_EN is defined.
package trace_pkg;

  localparam int TRACE_ADDR_W = 9;
  localparam int TRACE_REG_W  = 5;
  localparam int TRACE_DATA_W = 32;

  typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]             ts;
`endif
    logic                    reg_v;
    logic [TRACE_REG_W-1:0]  reg_num;
    logic [TRACE_DATA_W-1:0] reg_data;
    logic                    mem_wr;
    logic                    mem_rd;
    logic [TRACE_ADDR_W-1:0] addr;
    logic [TRACE_DATA_W-1:0] mem_data;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo_mem.sv
// trace_fifo_mem: DEPTH x trace_entry_t storage array for trace_buffer.
// Ports:
//   clk          - write clock
//   we/waddr     - write enable and write index
//   wdata        - entry to store
//   raddr/rdata  - asynchronous read index and entry
// The array contents are deliberately not reset. The read port is
// combinational, so an entry written on one edge is visible in the next cycle.
module trace_fifo_mem
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  trace_entry_t  wdata,
  input  logic [AW-1:0] raddr,
  output trace_entry_t  rdata
);

  trace_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/trace_buffer.sv
// trace_buffer: captures core retirement events into a FIFO of trace entries.
// Each entry records a register write and/or a data-memory access.
// Ports:
//   clk, reset (async, active low)
//   reg_num/reg_data/reg_write_sig  - retiring register write
//   wr/rd/addr/wr_data/rd_data      - data-memory access
//   clear                           - synchronous flush; also clears overflow
//                                     and drop_cnt
//   t_valid/t_ready                 - output handshake; t_* carry the head entry
//   level                           - occupancy, 0..DEPTH
//   overflow/drop_cnt               - sticky drop flag and saturating drop count
// Optional: TRACE_TIMESTAMP_EN adds a free-running 32-bit cycle counter and
//   the t_ts output, which carries the counter value of the capture cycle.
module trace_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [TRACE_REG_W-1:0]  reg_num,
  input  logic [DATA_W-1:0]       reg_data,
  input  logic                    reg_write_sig,
  input  logic                    wr,
  input  logic                    rd,
  input  logic [TRACE_ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [DATA_W-1:0]       rd_data,
  input  logic                    clear,
  output logic                    t_valid,
  input  logic                    t_ready,
  output logic                    t_reg_v,
  output logic [TRACE_REG_W-1:0]  t_reg_num,
  output logic [DATA_W-1:0]       t_reg_data,
  output logic                    t_mem_wr,
  output logic                    t_mem_rd,
  output logic [TRACE_ADDR_W-1:0] t_addr,
  output logic [DATA_W-1:0]       t_mem_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [15:0]             drop_cnt
`ifdef TRACE_TIMESTAMP_EN
  ,
  output logic [31:0]             t_ts
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          reg_v;
  logic          event_v;
  logic          is_full;
  logic          pop;
  logic          push;
  logic          drop;
  trace_entry_t  cap_entry;
  trace_entry_t  mem_head;
  trace_entry_t  head_out;

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + 32'd1;
  end
`endif

  assign reg_v   = reg_write_sig && (reg_num != '0);
  assign event_v = reg_v || wr || rd;
  assign is_full = (level == FULL_LEVEL);
  assign t_valid = (level != '0);

  // Popping in the same cycle frees a slot, so a full buffer still accepts.
  // clear discards both the same-cycle event and the pop.
  assign pop  = t_valid && t_ready && !clear;
  assign push = event_v && (!is_full || pop) && !clear;
  assign drop = event_v && is_full && !pop && !clear;

  // Unused fields of an entry are stored as zero.
  always_comb begin
    cap_entry        = '0;
    cap_entry.reg_v  = reg_v;
    cap_entry.mem_wr = wr;
    cap_entry.mem_rd = rd;
    if (reg_v) begin
      cap_entry.reg_num  = reg_num;
      cap_entry.reg_data = reg_data;
    end
    if (wr || rd) cap_entry.addr = addr;
    if (wr)       cap_entry.mem_data = wr_data;
    else if (rd)  cap_entry.mem_data = rd_data;
`ifdef TRACE_TIMESTAMP_EN
    cap_entry.ts = ts_cnt;
`endif
  end

  trace_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (cap_entry),
    .raddr (rd_ptr),
    .rdata (mem_head)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // Stale array contents must not leak out while the buffer is empty.
  always_comb begin
    head_out = '0;
    if (t_valid) head_out = mem_head;
  end

  assign t_reg_v    = head_out.reg_v;
  assign t_reg_num  = head_out.reg_num;
  assign t_reg_data = head_out.reg_data;
  assign t_mem_wr   = head_out.mem_wr;
  assign t_mem_rd   = head_out.mem_rd;
  assign t_addr     = head_out.addr;
  assign t_mem_data = head_out.mem_data;
`ifdef TRACE_TIMESTAMP_EN
  assign t_ts       = head_out.ts;
`endif

endmodule

// File: tb/tb_trace_buffer.sv
module tb_trace_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [4:0]    reg_num = '0;
  logic [DW-1:0] reg_data = '0;
  logic          reg_write_sig = 1'b0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [8:0]    addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data = '0;
  logic          clear = 1'b0;
  logic          t_ready = 1'b0;

  logic          t_valid;
  logic          t_reg_v;
  logic [4:0]    t_reg_num;
  logic [DW-1:0] t_reg_data;
  logic          t_mem_wr;
  logic          t_mem_rd;
  logic [8:0]    t_addr;
  logic [DW-1:0] t_mem_data;
  logic [3:0]    level;
  logic          overflow;
  logic [15:0]   drop_cnt;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]   t_ts;
`endif

  int errors = 0;
  int checks = 0;

  trace_buffer #(
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .reg_num       (reg_num),
    .reg_data      (reg_data),
    .reg_write_sig (reg_write_sig),
    .wr            (wr),
    .rd            (rd),
    .addr          (addr),
    .wr_data       (wr_data),
    .rd_data       (rd_data),
    .clear         (clear),
    .t_valid       (t_valid),
    .t_ready       (t_ready),
    .t_reg_v       (t_reg_v),
    .t_reg_num     (t_reg_num),
    .t_reg_data    (t_reg_data),
    .t_mem_wr      (t_mem_wr),
    .t_mem_rd      (t_mem_rd),
    .t_addr        (t_addr),
    .t_mem_data    (t_mem_data),
    .level         (level),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt)
`ifdef TRACE_TIMESTAMP_EN
    ,
    .t_ts          (t_ts)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of captured events plus drop bookkeeping.
  typedef struct {
    bit        reg_v;
    bit [4:0]  reg_num;
    bit [31:0] reg_data;
    bit        mem_wr;
    bit        mem_rd;
    bit [8:0]  addr;
    bit [31:0] mem_data;
  } ent_t;

  ent_t q[$];
  bit   m_ovf  = 1'b0;
  int   m_drop = 0;

  function automatic ent_t zero_ent();
    ent_t e;
    e.reg_v = 0; e.reg_num = 0; e.reg_data = 0; e.mem_wr = 0;
    e.mem_rd = 0; e.addr = 0; e.mem_data = 0;
    return e;
  endfunction

  function automatic ent_t head();
    if (q.size() > 0) return q[0];
    return zero_ent();
  endfunction

  function automatic ent_t capture();
    ent_t e = zero_ent();
    e.reg_v = reg_write_sig && (reg_num != 0);
    if (e.reg_v) begin
      e.reg_num  = reg_num;
      e.reg_data = reg_data;
    end
    e.mem_wr = wr;
    e.mem_rd = rd;
    if (wr || rd) e.addr = addr;
    e.mem_data = wr ? wr_data : (rd ? rd_data : 32'd0);
    return e;
  endfunction

  // Advance the model by one clock using the currently driven inputs, then
  // move to 1 time unit after the rising edge.
  task automatic tick();
    bit   ev = (reg_write_sig && reg_num != 0) || wr || rd;
    ent_t e  = capture();
    if (clear) begin
      q.delete();
      m_ovf  = 0;
      m_drop = 0;
    end else begin
      if (q.size() > 0 && t_ready) void'(q.pop_front());
      if (ev) begin
        if (q.size() < DEPTH) q.push_back(e);
        else begin
          m_ovf = 1;
          if (m_drop < 65535) m_drop++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_write_sig = 0; reg_num = 0; reg_data = 0;
    wr = 0; rd = 0; addr = 0; wr_data = 0; rd_data = 0; clear = 0;
  endtask

  task automatic set_reg(input bit [4:0] n, input bit [31:0] d);
    idle();
    reg_write_sig = 1; reg_num = n; reg_data = d;
  endtask

  task automatic test_reset();
    idle();
    t_ready = 0;
    reset = 0;
    set_reg(5'd3, 32'h55);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (t_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", t_valid); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if ({overflow, drop_cnt} !== 17'd0) begin errors++; $display("FAIL reset_ovf_drop: got %0b/%0d expected 0/0", overflow, drop_cnt); end
    checks++; if ({t_reg_v, t_reg_num, t_reg_data, t_mem_wr, t_mem_rd, t_addr, t_mem_data} !== '0) begin
      errors++; $display("FAIL reset_fields: got %0h/%0h/%0h/%0h expected all 0", t_reg_num, t_reg_data, t_addr, t_mem_data);
    end
    idle();
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    t_ready = 0;
    set_reg(5'd5, 32'h1234);
    #1;
    checks++; if (t_valid !== 1'b0) begin errors++; $display("FAIL no_bypass: got t_valid=%0b expected 0", t_valid); end
    tick();
    idle();
    checks++; if ({t_valid, t_reg_v, t_reg_num, t_mem_wr} !== {1'b1, 1'b1, 5'd5, 1'b0}) begin
      errors++; $display("FAIL single_head: got v=%0b rv=%0b num=%0d mw=%0b expected 1 1 5 0", t_valid, t_reg_v, t_reg_num, t_mem_wr);
    end
    checks++; if (t_reg_data !== 32'h1234) begin errors++; $display("FAIL single_data: got %0h expected 1234", t_reg_data); end
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL single_level: got %0d expected 1", level); end
    t_ready = 1;
    tick();
    checks++; if ({t_valid, level, t_reg_num, t_reg_data} !== '0) begin
      errors++; $display("FAIL single_drain: got v=%0b lvl=%0d num=%0d data=%0h expected all 0", t_valid, level, t_reg_num, t_reg_data);
    end
  endtask

  task automatic test_reg0();
    t_ready = 0;
    set_reg(5'd0, 32'hFFFF);
    tick();
    checks++; if ({t_valid, level} !== 5'd0) begin errors++; $display("FAIL reg0_no_push: got v=%0b lvl=%0d expected 0 0", t_valid, level); end
    set_reg(5'd0, 32'hFFFF);
    wr = 1; addr = 9'h010; wr_data = 32'h77;
    tick();
    idle();
    checks++; if ({t_reg_v, t_reg_data, t_mem_wr, t_addr, level} !== {1'b0, 32'd0, 1'b1, 9'h010, 4'd1}) begin
      errors++; $display("FAIL reg0_with_wr: got rv=%0b rd=%0h mw=%0b a=%0h lvl=%0d expected 0 0 1 10 1", t_reg_v, t_reg_data, t_mem_wr, t_addr, level);
    end
    t_ready = 1;
    tick();
  endtask

  task automatic test_overflow();
    t_ready = 0;
    for (int i = 1; i <= 10; i++) begin
      set_reg(5'((i % 31) + 1), 32'(i));
      tick();
    end
    idle();
    checks++; if ({level, overflow, drop_cnt} !== {4'd8, 1'b1, 16'd2}) begin
      errors++; $display("FAIL ovf_state: got lvl=%0d ovf=%0b drop=%0d expected 8 1 2", level, overflow, drop_cnt);
    end
    checks++; if (t_reg_data !== 32'd1) begin errors++; $display("FAIL ovf_head_hold: got %0h expected 1", t_reg_data); end
    t_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      checks++; if ({t_valid, t_reg_data} !== {1'b1, 32'(i)}) begin
        errors++; $display("FAIL drain_order_%0d: got v=%0b data=%0h expected 1 %0h", i, t_valid, t_reg_data, i);
      end
      tick();
    end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL drain_empty: got %0d expected 0", level); end
    t_ready = 0;
    for (int i = 1; i <= 8; i++) begin
      set_reg(5'd9, 32'(100 + i));
      tick();
    end
    set_reg(5'd9, 32'd200);
    t_ready = 1;
    tick();
    idle();
    t_ready = 0;
    checks++; if ({level, drop_cnt, t_reg_data} !== {4'd8, 16'd2, 32'd102}) begin
      errors++; $display("FAIL full_pop_accept: got lvl=%0d drop=%0d head=%0h expected 8 2 66", level, drop_cnt, t_reg_data);
    end
    set_reg(5'd9, 32'd300);
    tick();
    idle();
    checks++; if ({level, drop_cnt} !== {4'd8, 16'd3}) begin
      errors++; $display("FAIL full_drop: got lvl=%0d drop=%0d expected 8 3", level, drop_cnt);
    end
    t_ready = 1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (t_reg_data !== head().reg_data) begin
        errors++; $display("FAIL refill_order_%0d: got %0h expected %0h", i, t_reg_data, head().reg_data);
      end
      tick();
    end
    t_ready = 0;
  endtask

  task automatic test_both_strobes();
    idle();
    t_ready = 0;
    wr = 1; rd = 1; addr = 9'h1A5; wr_data = 32'hAA; rd_data = 32'hBB;
    tick();
    idle();
    rd = 1; addr = 9'h033; rd_data = 32'hBB; wr_data = 32'hCC;
    tick();
    idle();
    checks++; if ({t_mem_wr, t_mem_rd, t_mem_data, t_addr, t_reg_v} !== {1'b1, 1'b1, 32'hAA, 9'h1A5, 1'b0}) begin
      errors++; $display("FAIL both_strobes: got mw=%0b mr=%0b md=%0h a=%0h rv=%0b expected 1 1 aa 1a5 0", t_mem_wr, t_mem_rd, t_mem_data, t_addr, t_reg_v);
    end
    t_ready = 1;
    tick();
    t_ready = 0;
    checks++; if ({t_mem_wr, t_mem_rd, t_mem_data, t_addr} !== {1'b0, 1'b1, 32'hBB, 9'h033}) begin
      errors++; $display("FAIL rd_only: got mw=%0b mr=%0b md=%0h a=%0h expected 0 1 bb 33", t_mem_wr, t_mem_rd, t_mem_data, t_addr);
    end
    t_ready = 1;
    tick();
    t_ready = 0;
  endtask

  task automatic test_clear();
    t_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_reg(5'd7, 32'(40 + i));
      tick();
    end
    set_reg(5'd8, 32'hDEAD);
    clear = 1;
    t_ready = 1;
    tick();
    idle();
    t_ready = 0;
    checks++; if ({level, t_valid, overflow, drop_cnt} !== '0) begin
      errors++; $display("FAIL clear: got lvl=%0d v=%0b ovf=%0b drop=%0d expected 0 0 0 0", level, t_valid, overflow, drop_cnt);
    end
  endtask

  task automatic test_random();
    logic [102:0] got;
    logic [102:0] exp;
    ent_t h;
    for (int i = 0; i < 600; i++) begin
      reg_write_sig = 1'($urandom_range(0, 1));
      reg_num  = 5'($urandom_range(0, 31));
      reg_data = $urandom();
      wr       = ($urandom_range(0, 3) == 0);
      rd       = ($urandom_range(0, 3) == 0);
      addr     = 9'($urandom_range(0, 511));
      wr_data  = $urandom();
      rd_data  = $urandom();
      clear    = ($urandom_range(0, 80) == 0);
      // Alternate slow and fast drain phases so the buffer fills and empties.
      t_ready  = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      tick();
      h   = head();
      exp = {(q.size() > 0), h.reg_v, h.reg_num, h.reg_data, h.mem_wr, h.mem_rd,
             h.addr, h.mem_data, 4'(q.size()), m_ovf, 16'(m_drop)};
      got = {t_valid, t_reg_v, t_reg_num, t_reg_data, t_mem_wr, t_mem_rd,
             t_addr, t_mem_data, level, overflow, drop_cnt};
      checks++; if (got !== exp) begin
        errors++; $display("FAIL random_cycle_%0d: got %h expected %h", i, got, exp);
      end
    end
    idle();
    t_ready = 0;
  endtask

  task automatic test_async_reset();
    idle();
    clear = 1;
    tick();
    idle();
    t_ready = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      set_reg(5'd4, 32'(500 + i));
      tick();
    end
    idle();
    #1;
    reset = 0;
    #1;
    checks++; if ({t_valid, level, overflow, drop_cnt, t_reg_data, t_reg_v, t_addr} !== '0) begin
      errors++; $display("FAIL async_reset: got v=%0b lvl=%0d ovf=%0b drop=%0d data=%0h expected all 0", t_valid, level, overflow, drop_cnt, t_reg_data);
    end
    q.delete();
    m_ovf  = 0;
    m_drop = 0;
    @(negedge clk);
    reset = 1;
    set_reg(5'd12, 32'hCAFE);
    tick();
    idle();
    checks++; if ({level, t_valid, t_reg_num, t_reg_data} !== {4'd1, 1'b1, 5'd12, 32'hCAFE}) begin
      errors++; $display("FAIL resume_after_reset: got lvl=%0d v=%0b num=%0d data=%0h expected 1 1 12 cafe", level, t_valid, t_reg_num, t_reg_data);
    end
    t_ready = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_reg0();
    test_overflow();
    test_both_strobes();
    test_clear();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trace_buffer.md
TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 Parameter DATA_W, default 32: width of register and memory data fields.
REQ-002 Parameter DEPTH, default 8: entry count; power of two, at least 2.
REQ-003 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset; asserted at 0.
REQ-005 Port reg_num / reg_data / reg_write_sig, input, 5 / DATA_W / 1: retiring register write from core trace.
REQ-006 Port wr / rd / addr, input, 1 / 1 / 9: data-memory write strobe, read strobe, word address.
REQ-007 Port wr_data / rd_data, input, DATA_W each: store data and load data.
REQ-008 Port clear, input, 1: synchronous flush request.
REQ-009 Port t_valid (out, 1) / t_ready (in, 1): output handshake.
REQ-010 Ports t_reg_v (1), t_reg_num (5), t_reg_data (DATA_W), t_mem_wr (1), t_mem_rd (1), t_addr (9), t_mem_data (DATA_W), all outputs: head entry fields.
REQ-011 Port level, output, $clog2(DEPTH)+1: current occupancy.
REQ-012 Port overflow, output, 1: sticky flag, set when an event is dropped.
REQ-013 Port drop_cnt, output, 16: count of dropped events.

Function
REQ-014 Event condition: (reg_write_sig and reg_num != 0) or wr or rd; a reg_num 0 write alone is not an event.
REQ-015 Each event cycle shall capture one entry: reg_v = reg_write_sig and reg_num != 0, plus reg_num, reg_data, mem_wr = wr, mem_rd = rd, addr, and mem_data.
REQ-016 mem_data selection: wr_data when wr = 1, else rd_data when rd = 1, else 0; wr and rd both high: both flags set, wr_data stored.
REQ-017 Fields of the entry not covered by REQ-015/016 shall be 0 (reg_num/reg_data when reg_v = 0, addr when no memory access).
REQ-018 Ordering: strict FIFO.
REQ-019 Latency: an event pushed into an empty buffer shall raise t_valid on the next cycle; no same-cycle bypass.
REQ-020 Pop shall occur when t_valid and t_ready are both 1; the next entry, if any, shall appear in the following cycle.
REQ-021 While t_valid = 1 and t_ready = 0, all t_* fields shall hold stable.
REQ-022 Full buffer with a simultaneous pop: the event shall be accepted; level is unchanged.
REQ-023 Full buffer without a pop: the event shall be dropped; overflow set to 1; drop_cnt incremented, saturating at 16'hFFFF.
REQ-024 Empty buffer: t_valid = 0 and t_* fields = 0; t_ready is ignored.
REQ-025 Pointers shall wrap modulo DEPTH; level shall reach DEPTH exactly when full.
REQ-026 clear = 1: empty the buffer, clear overflow and drop_cnt on the next edge; any same-cycle event and pop shall be discarded.

Reset
REQ-027 On reset = 0, regardless of clk: pointers and level = 0, t_valid = 0, all t_* fields = 0, overflow = 0, drop_cnt = 0.
REQ-028 Reset asserted mid-traffic shall discard all stored entries; capture shall resume on the first edge after release.

Configuration
REQ-029 Macro TRACE_TIMESTAMP_EN defined: add a 32-bit free-running cycle counter (reset to 0, wrapping) and output port t_ts (32 bits), holding the counter value of the capture cycle.
REQ-030 Macro TRACE_TIMESTAMP_EN undefined: no counter, no t_ts port, no timestamp storage.

Structure
REQ-031 Package trace_pkg shall hold the trace_entry_t packed struct (fields per REQ-015, ts under the macro) and the TRACE_ADDR_W = 9 constant.
REQ-032 Storage shall be a sub-module trace_fifo_mem: DEPTH x trace_entry_t, one write port and one read port, no reset on array contents.

Verification
REQ-033 Event reg_num = 5, reg_data = 0x1234, wr = 0, rd = 0 into an empty buffer -> next cycle t_valid = 1, t_reg_v = 1, t_reg_num = 5, t_mem_wr = 0, level = 1.
REQ-034 reg_write_sig = 1 with reg_num = 0 and no memory strobe -> no push, level = 0.
REQ-035 t_ready = 0 with 10 consecutive events (DEPTH 8) -> level = 8, overflow = 1, drop_cnt = 2; draining returns events 1 to 8 in order.
REQ-036 Full buffer, event with t_ready = 1 -> accepted, level stays 8, drop_cnt unchanged.
REQ-037 wr = 1 and rd = 1 with addr = 0x1A5, wr_data = 0xAA, rd_data = 0xBB -> t_mem_wr = 1, t_mem_rd = 1, t_mem_data = 0xAA.
REQ-038 clear pulse with 3 entries and an event in the same cycle -> next cycle level = 0, t_valid = 0, overflow = 0; mid-run reset = 0 -> all outputs 0 asynchronously.
